apb_slave_regs: RTL and testbench



---
 rtl/apb_slave_regs.sv | 165 ++++++++++++++++
 tb/tb_apb_slave_regs.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regs
// Brief    : APB completer serving a bank of 32-bit read/write registers.
//            Optional macro APB_SLV_WAIT_EN inserts WAIT_STATES access cycles.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regs #(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [7:0]  PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR
);

  localparam int         c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int         c_DEPTH = 1 << c_IDX_W;
  localparam logic [6:0] c_NUM   = 7'(NUM_REGS);

  generate
    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_bad_num_regs
      $error("apb_slave_regs: NUM_REGS must be in 1..64");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("apb_slave_regs: WAIT_STATES must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_regs [c_DEPTH];
  logic [7:0]          r_addr;
  logic                r_write;
  logic [31:0]         r_wdata;
  logic                r_pready;
  logic                r_pslverr;
  logic [31:0]         r_prdata;
  logic                w_setup;
  logic                w_rsp_fire;
  logic [7:0]          w_rsp_addr;
  logic                w_rsp_write;
  logic                w_rsp_err;
  logic [c_IDX_W-1:0]  w_rsp_idx;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic                w_commit;

  assign w_setup = PSEL & ~PENABLE;

  // With zero wait states the response is formed in the setup cycle itself,
  // so the live bus fields are used there and the latched copies afterwards.
  assign w_rsp_addr  = (r_state == S_IDLE) ? PADDR  : r_addr;
  assign w_rsp_write = (r_state == S_IDLE) ? PWRITE : r_write;
  assign w_rsp_err   = (w_rsp_addr[1:0] != 2'b00) || ({1'b0, w_rsp_addr[7:2]} >= c_NUM);
  assign w_rsp_idx   = w_rsp_addr[c_IDX_W+1:2];
  assign w_wr_idx    = r_addr[c_IDX_W+1:2];
  assign w_commit    = (r_state == S_DONE) && PSEL && PENABLE && r_pready
                       && r_write && !r_pslverr;

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] c_WAITS = 4'(WAIT_STATES);
  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_nxt;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wait_cnt <= 4'd0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_rsp_fire  = 1'b0;
`ifdef APB_SLV_WAIT_EN
    w_wait_nxt  = r_wait_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
`ifdef APB_SLV_WAIT_EN
          w_wait_nxt = c_WAITS;
          if (c_WAITS == 4'd0) begin
            w_rsp_fire  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ACCESS;
          end
`else
          w_rsp_fire  = 1'b1;
          w_state_nxt = S_DONE;
`endif
        end
      end
      S_ACCESS: begin
`ifdef APB_SLV_WAIT_EN
        // Response is registered on the edge that consumes the last wait cycle.
        if (!PSEL) begin
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt <= 4'd1) begin
          w_wait_nxt  = 4'd0;
          w_rsp_fire  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_wait_nxt = r_wait_cnt - 4'd1;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= 32'h0;
      r_addr    <= 8'h0;
      r_write   <= 1'b0;
      r_wdata   <= 32'h0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_pready  <= w_rsp_fire;
      r_pslverr <= w_rsp_fire & w_rsp_err;
      r_prdata  <= (w_rsp_fire && !w_rsp_write && !w_rsp_err) ? r_regs[w_rsp_idx] : 32'h0;
      if ((r_state == S_IDLE) && w_setup) begin
        r_addr  <= PADDR;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
      end
      if (w_commit) begin
        r_regs[w_wr_idx] <= r_wdata;
      end
    end
  end

  assign PREADY  = r_pready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regs
// Brief    : Scoreboard bench for apb_slave_regs against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regs;

  localparam int          c_NUM_REGS  = 16;
  localparam logic [31:0] c_RESET_VAL = 32'h5A5A_0001;
  localparam int          c_WAIT_CFG  = 3;
`ifdef APB_SLV_WAIT_EN
  localparam int c_W = c_WAIT_CFG;
`else
  localparam int c_W = 0;
`endif
  localparam int c_BUDGET = 32;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_slave_regs #(
    .NUM_REGS    (c_NUM_REGS),
    .RESET_VAL   (c_RESET_VAL),
    .WAIT_STATES (c_WAIT_CFG)
  ) u_dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        m_x;
  logic [31:0] m_regs [c_NUM_REGS];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [7:0] a);
    return ((int'(a) % 4) != 0) || ((int'(a) / 4) >= c_NUM_REGS);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < c_NUM_REGS; i++) m_regs[i] = c_RESET_VAL;
  endfunction

  function automatic void expect_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d);
    exp_t x;
    x.err  = addr_err(a);
    x.data = (!wr && !x.err) ? m_regs[int'(a) / 4] : 32'h0;
    q.push_back(x);
    if (wr && !x.err) m_regs[int'(a) / 4] = d;
  endfunction

  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d);
    int lat;
    expect_xfer(wr, a, d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    lat = 1;
    while (PREADY !== 1'b1 && lat < c_BUDGET) begin
      @(posedge PCLK); #1;
      lat++;
    end
    check("access_latency", 32'(lat), 32'(c_W + 1));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

`ifdef APB_SLV_WAIT_EN
  task automatic abort_write(input logic [7:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (c_W + 1) begin
      @(posedge PCLK); #1;
      check("pready_after_abort", 32'(PREADY), 32'h0);
    end
  endtask
`endif

  task automatic reset_mid_write();
    exp_t x;
    // Without wait states the only access cycle already shows the response.
    if (c_W == 0) begin
      x.data = 32'h0; x.err = 1'b0;
      q.push_back(x);
    end
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'hFFFF_FFFF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    check("pready_after_reset", 32'(PREADY), 32'h0);
  endtask

  always @(negedge PCLK) begin
    if (mon_en) begin
      if (PREADY === 1'b1 && q.size() > 0) begin
        m_x = q.pop_front();
        check("prdata", PRDATA, m_x.data);
        check("pslverr", 32'(PSLVERR), 32'(m_x.err));
      end else begin
        if (q.size() == 0) check("pready_unsolicited", 32'(PREADY), 32'h0);
        if (PREADY !== 1'b1) begin
          check("prdata_idle", PRDATA, 32'h0);
          check("pslverr_idle", 32'(PSLVERR), 32'h0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    int          r;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 32'h0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    check("reset_pready", 32'(PREADY), 32'h0);
    check("reset_prdata", PRDATA, 32'h0);
    check("reset_pslverr", 32'(PSLVERR), 32'h0);
    PRESET = 1'b0;
    mon_en = 1'b1;
    @(posedge PCLK); #1;

    xfer(1'b0, 8'h00, 32'h0);
    xfer(1'b1, 8'h08, 32'hDEAD_BEEF);
    xfer(1'b0, 8'h08, 32'h0);
    xfer(1'b0, 8'h04, 32'h0);
    xfer(1'b0, 8'h0C, 32'h0);
    xfer(1'b1, 8'h3C, 32'h0BAD_F00D);
    xfer(1'b1, 8'h40, 32'h1111_2222);
    xfer(1'b0, 8'h3C, 32'h0);
    xfer(1'b0, 8'h05, 32'h0);
    xfer(1'b1, 8'h10, 32'h1234_5678);
    xfer(1'b0, 8'h10, 32'h0);
`ifdef APB_SLV_WAIT_EN
    abort_write(8'h14, 32'hA5A5_A5A5);
    xfer(1'b0, 8'h14, 32'h0);
`endif
    reset_mid_write();
    xfer(1'b0, 8'h00, 32'h0);
    xfer(1'b0, 8'h08, 32'h0);
    xfer(1'b1, 8'h00, 32'h600D_CAFE);
    xfer(1'b0, 8'h00, 32'h0);

    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 8'($urandom_range(0, c_NUM_REGS - 1) * 4);
      else if (r == 7) a = 8'(($urandom_range(0, 63) * 4) + $urandom_range(1, 3));
      else             a = 8'($urandom_range(c_NUM_REGS, 63) * 4);
      d = $urandom;
      xfer($urandom_range(0, 1) == 1, a, d);
      repeat ($urandom_range(0, 2)) begin
        // Occasional protocol violation while idle must be ignored.
        PSEL    = ($urandom_range(0, 3) == 0);
        PENABLE = PSEL;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
      end
    end

    repeat (c_W + 4) @(posedge PCLK);
    #1;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
